// File: rtl/la_mailbox_pkg.sv
// Register map and STATUS layout shared by the mailbox top and its bench-facing decode.
// Offsets are word indices on each bus; STATUS fields are bit positions in the 32-bit word.
package la_mailbox_pkg;

  // Port A (microwatt, 64-bit word address) register indices
  localparam logic [1:0] LA_TX     = 2'd0;
  localparam logic [1:0] LA_RX     = 2'd1;
  localparam logic [1:0] LA_STATUS = 2'd2;
  localparam logic [1:0] LA_RSVD   = 2'd3;

  // Port B (Caravel, byte address bits [3:2]) register indices
  localparam logic [1:0] WB_RX     = 2'd0;
  localparam logic [1:0] WB_TX     = 2'd1;
  localparam logic [1:0] WB_STATUS = 2'd2;
  localparam logic [1:0] WB_CTRL   = 2'd3;

  localparam int ST_C2M_CNT   = 0;
  localparam int ST_M2C_CNT   = 8;
  localparam int ST_C2M_EMPTY = 16;
  localparam int ST_C2M_FULL  = 17;
  localparam int ST_M2C_EMPTY = 18;
  localparam int ST_M2C_FULL  = 19;
  localparam int ST_C2M_OVF   = 20;
  localparam int ST_M2C_OVF   = 21;

  localparam int CTRL_FLUSH_BIT = 0;

  function automatic logic [31:0] pack_status(
    input logic [7:0] c2m_cnt,
    input logic [7:0] m2c_cnt,
    input logic       c2m_empty,
    input logic       c2m_full,
    input logic       m2c_empty,
    input logic       m2c_full,
    input logic       c2m_ovf,
    input logic       m2c_ovf
  );
    logic [31:0] s;
    s = '0;
    s[ST_C2M_CNT +: 8] = c2m_cnt;
    s[ST_M2C_CNT +: 8] = m2c_cnt;
    s[ST_C2M_EMPTY]    = c2m_empty;
    s[ST_C2M_FULL]     = c2m_full;
    s[ST_M2C_EMPTY]    = m2c_empty;
    s[ST_M2C_FULL]     = m2c_full;
    s[ST_C2M_OVF]      = c2m_ovf;
    s[ST_M2C_OVF]      = m2c_ovf;
    return s;
  endfunction

endpackage

// File: rtl/mbox_fifo.sv
// Synchronous first-word-fall-through FIFO with flush and sticky overflow.
// Latency: a push is visible on dout/count the cycle after it is taken.
// Backpressure: none; a push while full is dropped unless a pop frees the slot in the same cycle.
module mbox_fifo #(
  parameter int DEPTH = 8,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [DW-1:0]            push_dat,
  input  logic                     pop,
  input  logic                     flush,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [DW-1:0]            dout,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          pop_ok;
  logic          push_ok;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign dout    = mem[rd_ptr];
  // A pop in the same cycle frees the head slot, so a push on full still lands
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  always_ff @(posedge clk) begin
    if (rst_n && !flush && push_ok) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push_ok && !pop_ok) begin
        count <= count + 1'b1;
      end else if (!push_ok && pop_ok) begin
        count <= count - 1'b1;
      end
      if (push && !push_ok) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/la_mailbox.sv
// Core<->mgmt message mailbox: pipelined 64-bit Wishbone (port A) and classic 32-bit Wishbone (port B).
// Latency: every accepted access is acked one cycle later with its read data.
// Backpressure: port A stalls only during reset; port B blocks a new access while its ack is high.
module la_mailbox
  import la_mailbox_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int DW    = 32
) (
  input  logic        ext_clk,
  input  logic        ext_rst,
  input  logic        la_cyc_i,
  input  logic        la_stb_i,
  input  logic        la_we_i,
  input  logic [31:0] la_adr_i,
  input  logic [7:0]  la_sel_i,
  input  logic [63:0] la_dat_i,
  output logic [63:0] la_dat_o,
  output logic        la_ack_o,
  output logic        la_stall_o,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_dat_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  output logic        irq_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic          la_acc;
  logic          wb_acc;
  logic [1:0]    la_reg;
  logic [1:0]    wb_reg;
  logic          c2m_push;
  logic          c2m_pop;
  logic          m2c_push;
  logic          m2c_pop;
  logic          flush;

  logic          c2m_full;
  logic          c2m_empty;
  logic [CW-1:0] c2m_count;
  logic [DW-1:0] c2m_dout;
  logic          c2m_ovf;
  logic          m2c_full;
  logic          m2c_empty;
  logic [CW-1:0] m2c_count;
  logic [DW-1:0] m2c_dout;
  logic          m2c_ovf;

  logic [31:0]   status;
  logic [31:0]   la_rdata;
  logic [31:0]   wb_rdata;
  logic          unused_inputs;

  assign unused_inputs = ^{la_sel_i, wbs_sel_i, la_adr_i[31:2], wbs_adr_i[31:4],
                           wbs_adr_i[1:0], la_dat_i[63:DW]};

  assign la_stall_o = ~ext_rst;
  assign la_acc     = la_cyc_i & la_stb_i & ~la_stall_o;
  assign wb_acc     = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
  assign la_reg     = la_adr_i[1:0];
  assign wb_reg     = wbs_adr_i[3:2];

  assign c2m_push = la_acc & la_we_i & (la_reg == LA_TX);
  assign m2c_pop  = la_acc & ~la_we_i & (la_reg == LA_RX);
  assign c2m_pop  = wb_acc & ~wbs_we_i & (wb_reg == WB_RX);
  assign m2c_push = wb_acc & wbs_we_i & (wb_reg == WB_TX);
  assign flush    = wb_acc & wbs_we_i & (wb_reg == WB_CTRL) & wbs_dat_i[CTRL_FLUSH_BIT];

  mbox_fifo #(.DEPTH(DEPTH), .DW(DW)) u_c2m (
    .clk      (ext_clk),
    .rst_n    (ext_rst),
    .push     (c2m_push),
    .push_dat (la_dat_i[DW-1:0]),
    .pop      (c2m_pop),
    .flush    (flush),
    .full     (c2m_full),
    .empty    (c2m_empty),
    .count    (c2m_count),
    .dout     (c2m_dout),
    .overflow (c2m_ovf)
  );

  mbox_fifo #(.DEPTH(DEPTH), .DW(DW)) u_m2c (
    .clk      (ext_clk),
    .rst_n    (ext_rst),
    .push     (m2c_push),
    .push_dat (wbs_dat_i[DW-1:0]),
    .pop      (m2c_pop),
    .flush    (flush),
    .full     (m2c_full),
    .empty    (m2c_empty),
    .count    (m2c_count),
    .dout     (m2c_dout),
    .overflow (m2c_ovf)
  );

  assign status = pack_status(8'(c2m_count), 8'(m2c_count), c2m_empty, c2m_full,
                              m2c_empty, m2c_full, c2m_ovf, m2c_ovf);
  assign irq_o  = ~c2m_empty;

  // A flush landing with a port A pop empties m2c first, so the pop reads nothing
  always_comb begin
    la_rdata = '0;
    case (la_reg)
      LA_RX:     if (!m2c_empty && !flush) la_rdata = 32'(m2c_dout);
      LA_STATUS: la_rdata = status;
      default:   la_rdata = '0;
    endcase
  end

  always_comb begin
    wb_rdata = '0;
    case (wb_reg)
      WB_RX:     if (!c2m_empty) wb_rdata = 32'(c2m_dout);
      WB_STATUS: wb_rdata = status;
      default:   wb_rdata = '0;
    endcase
  end

  always_ff @(posedge ext_clk) begin
    if (!ext_rst) begin
      la_ack_o  <= 1'b0;
      la_dat_o  <= '0;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      la_ack_o  <= la_acc;
      la_dat_o  <= (la_acc && !la_we_i) ? {32'b0, la_rdata} : 64'b0;
      wbs_ack_o <= wb_acc;
      wbs_dat_o <= (wb_acc && !wbs_we_i) ? wb_rdata : 32'b0;
    end
  end

endmodule

// File: doc/la_mailbox.md
Name: la_mailbox

Overview:
- Bidirectional message mailbox between the microwatt core and the Caravel management SoC.
- Downstream of microwatt: consumes microwatt's wb_la_* pipelined 64-bit Wishbone master (port A).
- Also serves the Caravel wbs_* 32-bit classic Wishbone slave bus (port B).
- Two 32-bit FIFOs: c2m (core→mgmt) and m2c (mgmt→core), plus status, flush and a mgmt interrupt.

Parameters:
- DEPTH, 8, entries per FIFO; power of two, 2..128.
- DW, 32, message width in bits.

Ports:
- ext_clk  in  1  sole clock; the user-project clk, both buses synchronous to it.
- ext_rst  in  1  synchronous, active-low reset.
- la_cyc_i  in  1  port A cycle, from microwatt wb_la_cyc.
- la_stb_i  in  1  port A strobe.
- la_we_i  in  1  port A write enable.
- la_adr_i  in  32  port A 64-bit-word address; only [1:0] decoded.
- la_sel_i  in  8  port A byte selects; ignored.
- la_dat_i  in  64  port A write data; [31:0] used.
- la_dat_o  out  64  port A read data, to microwatt wb_la_dat_i.
- la_ack_o  out  1  port A ack.
- la_stall_o  out  1  port A stall.
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  port B classic controls.
- wbs_adr_i  in  32  port B byte address; only [3:2] decoded.
- wbs_sel_i  in  4  ignored.
- wbs_dat_i  in  32  port B write data.
- wbs_dat_o  out  32  port B read data.
- wbs_ack_o  out  1  port B ack.
- irq_o  out  1  level interrupt: c2m FIFO non-empty.

Behaviour:
- Reset (ext_rst=0 at a rising edge): both FIFOs empty, pointers 0, overflow flags 0. la_ack_o=0, wbs_ack_o=0, la_dat_o=0, wbs_dat_o=0, irq_o=0. la_stall_o=1 while ext_rst=0, 0 otherwise.
- A request in flight when reset is asserted is abandoned: no ack is issued and no FIFO update occurs.
- Port A map (la_adr_i[1:0]):
  - 0 TX: write pushes la_dat_i[31:0] into c2m; read returns 0.
  - 1 RX: read pops m2c and returns {32'b0, data}; write is ignored.
  - 2 STATUS: read only.
  - 3: reads 0, writes ignored.
- Port B map (wbs_adr_i[3:2]):
  - 0 RX: read pops c2m.
  - 1 TX: write pushes wbs_dat_i into m2c.
  - 2 STATUS: read only.
  - 3 CTRL: write with bit0=1 flushes both FIFOs and clears both overflow flags; reads 0.
- STATUS (32 bits, zero-extended to 64 on port A):
  - [7:0] c2m count; [15:8] m2c count.
  - [16] c2m empty; [17] c2m full; [18] m2c empty; [19] m2c full.
  - [20] c2m overflow (sticky); [21] m2c overflow (sticky); others 0.
- Port A handshake:
  - Accept when la_cyc_i & la_stb_i & !la_stall_o.
  - la_ack_o is registered, high exactly one cycle after each accept; la_dat_o is valid with it.
  - Back-to-back accepts give back-to-back acks; no stall after reset.
- Port B handshake:
  - Access when wbs_cyc_i & wbs_stb_i & !wbs_ack_o.
  - wbs_ack_o is a one-cycle pulse on the next cycle; wbs_dat_o is valid with it.
  - Side effects happen once per ack.
- Push on full: data dropped, overflow flag set. Exception: a pop of the same FIFO in the same cycle makes the push succeed, count unchanged, no overflow.
- Pop on empty: returns 0, no pointer change, no underflow flag. A same-cycle push does not satisfy the pop; the pop sees the pre-cycle state.
- Simultaneous push and pop on a non-empty, non-full FIFO: both take effect, count unchanged.
- Flush in the same cycle as a port A push or pop: flush wins. Push data is discarded; a pop returns 0.
- Pointers wrap modulo DEPTH. Count is log2(DEPTH)+1 bits, zero-extended into the 8-bit STATUS fields.
- irq_o is driven from registered state: high the cycle after the first c2m push accept, low the cycle after the pop that empties c2m.

Decomposition:
- Package la_mailbox_pkg holds:
  - port A and port B address offsets (TX/RX/STATUS/CTRL);
  - STATUS bit positions;
  - the CTRL flush bit.
- Sub-module mbox_fifo: synchronous FIFO with parameters DEPTH and DW.
  - Signals: push, pop, flush, full, empty, count, dout (first-word-fall-through), overflow sticky.
  - Instantiated twice (c2m, m2c).

Test Plan:
- Reset: hold ext_rst=0 for 3 cycles → acks 0, irq_o 0, la_stall_o 1; after release, STATUS reads 0x00050000 on both ports.
- Core→mgmt: port A writes 0xDEADBEEF then 0x12345678 to addr 0 back-to-back → acks on two consecutive cycles; irq_o rises the cycle after the first accept. Port B reads 0x0 twice → 0xDEADBEEF, 0x12345678; irq_o falls after the second read.
- Overflow: 9 port A pushes (values 1..9) → STATUS c2m count 8, bits 17 and 20 set; 8 port B pops return 1..8. Then CTRL write 0x1 → STATUS 0x00050000.
- Mgmt→core and empty read: port B writes 0xA5A5A5A5 to 0x4; port A reads addr 1 → 0x00000000A5A5A5A5. A second read returns 0, and STATUS m2c count stays 0.
- Full with concurrent pop: fill c2m to 8, then issue a port A push and a port B pop in the same cycle → count stays 8, overflow bit 20 stays 0, FIFO order preserved.
- Reset mid-operation: port A push accepted, ext_rst=0 on the next edge → no la_ack_o; after release, STATUS = 0x00050000.
